// File: rtl/apb3_mem_slave_pkg.sv
// Shared types and helpers for the APB3 memory completer.
`timescale 1ns/1ps
package apb3_pkg;

  localparam int MAX_WAIT = 15;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/apb3_mem_array.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, registered read port.
`timescale 1ns/1ps
module apb3_mem_array #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 8
) (
  input  logic                  pclk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // No reset on storage or the read register so this maps onto block RAM.
  always_ff @(posedge pclk) begin
    if (we) mem[widx] <= wdata;
    if (re) rdata <= mem[ridx];
  end

endmodule

// File: rtl/apb3_mem_slave.sv
// APB3 completer with word-addressed RAM, wait states and pslverr.
// Optional write-protected region enabled by defining APB3_MEM_SLAVE_WP_EN.
`timescale 1ns/1ps
module apb3_mem_slave
  import apb3_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int RO_BASE     = 192
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pwrite,
  input  logic                  psel,
  input  logic                  penable,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int ADDR_LSB   = clog2(DATA_WIDTH / 8);
  localparam int IDX_W      = ADDR_WIDTH - ADDR_LSB;
  localparam int MW         = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int WAIT_CLAMP = (WAIT_STATES > MAX_WAIT) ? MAX_WAIT : WAIT_STATES;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CLAMP);
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((1 << ADDR_LSB) - 1);

  // Handshake: psel & ~penable is the setup cycle; the transfer completes on the
  // first cycle with psel & penable & pready. pslverr/prdata are valid only then.
  state_t               state;
  logic [3:0]           cnt;
  logic                 err_q;
  logic                 pwrite_q;
  logic [MW-1:0]        idx_q;
  logic                 rd_ok;

  logic [IDX_W-1:0]      idx;
  logic                  setup;
  logic                  xfer;
  logic                  range_err;
  logic                  align_err;
  logic                  wp_err;
  logic                  req_err;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign idx       = paddr[ADDR_WIDTH-1:ADDR_LSB];
  assign setup     = psel & ~penable;
  assign xfer      = psel & penable;
  assign range_err = 32'(idx) >= DEPTH;
  assign align_err = |(paddr & LSB_MASK);

`ifdef APB3_MEM_SLAVE_WP_EN
  assign wp_err = pwrite & (32'(idx) >= RO_BASE);
`else
  assign wp_err = 1'b0;
`endif

  assign req_err = range_err | align_err | wp_err;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state    <= IDLE;
      cnt      <= '0;
      err_q    <= 1'b0;
      pwrite_q <= 1'b0;
      idx_q    <= '0;
      rd_ok    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            state    <= ACCESS;
            cnt      <= WAIT_INIT;
            err_q    <= req_err;
            pwrite_q <= pwrite;
            idx_q    <= idx[MW-1:0];
            // A read setup decides whether prdata shows RAM data or zero.
            if (!pwrite) rd_ok <= ~req_err;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (penable) begin
            if (cnt != 4'd0) cnt <= cnt - 4'd1;
            else             state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_re  = (state == IDLE) & setup & ~pwrite & ~req_err;
  assign mem_we  = (state == ACCESS) & xfer & (cnt == 4'd0) & pwrite_q & ~err_q;

  assign pready  = (state == ACCESS) & (cnt == 4'd0);
  assign pslverr = err_q & pready;
  assign prdata  = rd_ok ? mem_rdata : '0;

  apb3_mem_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (MW)
  ) u_mem (
    .pclk  (pclk),
    .we    (mem_we),
    .widx  (idx_q),
    .wdata (pwdata),
    .re    (mem_re),
    .ridx  (idx[MW-1:0]),
    .rdata (mem_rdata)
  );

endmodule
